// File: rtl/ttl_bcd_timer_ctrl.sv
// Sequencer driving a cascade of 162-style synchronous-clear BCD decade counters.
// Latency: start->LOAD 1 cycle, LOAD->RUN 1 cycle; done/err are registered (1 cycle after the event).
// Backpressure: none; start is honoured only in IDLE, abort only in LOAD/RUN/PAUSE, pause holds the count.
//
// Ports:
//   clk, MR_n                 clock, asynchronous active-low reset
//   start, abort, pause       control (start/abort pulses, pause level)
//   auto_reload, preset       captured when start is accepted; preset digit 0 in [3:0]
//   cnt_TC                    ripple terminal count from the last digit of the chain
//   cnt_SR_n, cnt_PE_n        chain synchronous clear / synchronous load
//   cnt_CEP, cnt_CET          chain count tick / digit-0 trickle enable
//   cnt_P                     latched preset to the chain parallel inputs
//   busy, done, err           state != IDLE, terminal-count pulse, invalid-preset pulse
module ttl_bcd_timer_ctrl #(
    parameter int DIGITS   = 2,
    parameter int PRESCALE = 1
) (
    input  logic                  clk,
    input  logic                  MR_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  pause,
    input  logic                  auto_reload,
    input  logic [4*DIGITS-1:0]   preset,
    input  logic                  cnt_TC,
    output logic                  cnt_SR_n,
    output logic                  cnt_PE_n,
    output logic                  cnt_CEP,
    output logic                  cnt_CET,
    output logic [4*DIGITS-1:0]   cnt_P,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_PAUSE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   prescaler;
    logic            reload_q;
    logic            preset_ok;
    logic            tick;
    logic            terminal;
    logic            accept;

    // Every preset nibble must be a legal BCD digit before the chain may load it.
    always_comb begin
        preset_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (preset[4*i +: 4] > 4'd9) begin
                preset_ok = 1'b0;
            end
        end
    end

    assign tick     = (state == ST_RUN) && (prescaler == PS_LAST);
    assign terminal = tick && cnt_TC;
    assign accept   = (state == ST_IDLE) && start && preset_ok;

    // Next-state decode. RUN priority: abort, then terminal count, then pause.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: state_nxt = ST_IDLE;
            ST_IDLE:  if (accept) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = abort ? ST_CLEAR : ST_RUN;
            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_CLEAR;
                end else if (terminal) begin
                    state_nxt = reload_q ? ST_RUN : ST_IDLE;
                end else if (pause) begin
                    state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (abort) begin
                    state_nxt = ST_CLEAR;
                end else if (!pause) begin
                    state_nxt = ST_RUN;
                end
            end
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    // Chain controls are pure decodes of state; the reload load is combinational
    // so PE_n overrides the 9..9 -> 0..0 wrap on the terminal edge itself.
    always_comb begin
        cnt_SR_n = (state != ST_CLEAR);
        cnt_CET  = (state == ST_RUN) || (state == ST_PAUSE);
        cnt_CEP  = tick;
        cnt_PE_n = !((state == ST_LOAD) || (terminal && reload_q));
        busy     = (state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge MR_n) begin
        if (!MR_n) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Prescaler advances on every RUN cycle (including the one that enters PAUSE),
    // holds in PAUSE and is parked at 0 everywhere else.
    always_ff @(posedge clk or negedge MR_n) begin
        if (!MR_n) begin
            prescaler <= '0;
        end else begin
            case (state)
                ST_RUN:   prescaler <= tick ? '0 : prescaler + PW'(1);
                ST_PAUSE: prescaler <= prescaler;
                default:  prescaler <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge MR_n) begin
        if (!MR_n) begin
            cnt_P    <= '0;
            reload_q <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (accept) begin
                cnt_P    <= preset;
                reload_q <= auto_reload;
            end
            done <= terminal && !abort;
            err  <= (state == ST_IDLE) && start && !preset_ok;
        end
    end

endmodule

// File: tb/tb_ttl_bcd_timer_ctrl.sv
// Bench for ttl_bcd_timer_ctrl: drives a behavioural two-digit 162-style chain from the DUT.
// Latency: expected done/err pulses are scheduled at absolute cycle numbers.
// Backpressure: none; stimulus runs open-loop per transaction.
module tb_ttl_bcd_timer_ctrl;

    localparam int D  = 2;
    localparam int PS = 3;

    logic         clk = 1'b0;
    logic         MR_n;
    logic         start, abort, pause, auto_reload;
    logic [4*D-1:0] preset;
    logic         cnt_TC;
    logic         cnt_SR_n, cnt_PE_n, cnt_CEP, cnt_CET;
    logic [4*D-1:0] cnt_P;
    logic         busy, done, err;

    logic [4*D-1:0] chain_q;
    logic           chain_force;
    int             cyc = 0;
    logic [4*D-1:0] last_p;

    typedef struct {
        bit             is_err;
        int             at;
        logic [4*D-1:0] q;
        bit             busy;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ttl_bcd_timer_ctrl #(.DIGITS(D), .PRESCALE(PS)) dut (
        .clk(clk), .MR_n(MR_n), .start(start), .abort(abort), .pause(pause),
        .auto_reload(auto_reload), .preset(preset), .cnt_TC(cnt_TC),
        .cnt_SR_n(cnt_SR_n), .cnt_PE_n(cnt_PE_n), .cnt_CEP(cnt_CEP), .cnt_CET(cnt_CET),
        .cnt_P(cnt_P), .busy(busy), .done(done), .err(err)
    );

    // Cascaded decade counters: digit i counts when CEP and all lower digits are 9.
    function automatic logic [4*D-1:0] chain_next(input logic [4*D-1:0] q, input logic sr_n,
                                                  input logic pe_n, input logic cep,
                                                  input logic cet, input logic [4*D-1:0] p);
        logic [4*D-1:0] n;
        logic           carry;
        if (!sr_n) return '0;
        if (!pe_n) return p;
        n     = q;
        carry = cet;
        for (int i = 0; i < D; i++) begin
            if (cep && carry) n[4*i +: 4] = (q[4*i +: 4] == 4'd9) ? 4'd0 : q[4*i +: 4] + 4'd1;
            carry = carry && (q[4*i +: 4] == 4'd9);
        end
        return n;
    endfunction

    always @(posedge clk)
        chain_q <= chain_force ? {D{4'h7}} : chain_next(chain_q, cnt_SR_n, cnt_PE_n, cnt_CEP, cnt_CET, cnt_P);

    assign cnt_TC = cnt_CET && (chain_q == {D{4'h9}});

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pulse monitor: each done/err pulse must match the oldest scheduled expectation.
    always @(negedge clk) begin
        if (MR_n === 1'b1 && (done === 1'b1 || err === 1'b1)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {30'd0, done, err}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_kind", {31'd0, err}, {31'd0, e.is_err});
                check("pulse_cycle", cyc, e.at);
                if (!e.is_err) begin
                    check("q_at_done", chain_q, e.q);
                    check("busy_at_done", {31'd0, busy}, {31'd0, e.busy});
                end
            end
        end
    end

    function automatic int interval(input logic [4*D-1:0] p);
        int v;
        v = 0;
        for (int i = D - 1; i >= 0; i--) v = v * 10 + int'(p[4*i +: 4]);
        return (100 - v) * PS;
    endfunction

    task automatic idle_inputs();
        start = 1'b0; abort = 1'b0; pause = 1'b0; auto_reload = 1'b0; preset = '0;
    endtask

    // One accepted interval. pr: RUN-cycle index at which pause rises (0 = none), pw: pause width,
    // ab: abort cycle relative to the start cycle (-1 = none), restart: extra ignored start pulse.
    task automatic run_txn(input logic [4*D-1:0] p, input bit rl, input int pr, input int pw,
                           input int ab, input bit restart);
        int s, n, w, a, t, e, ps, rs;
        exp_t x;
        s  = cyc;
        n  = interval(p);
        w  = (pr > 0) ? pw : 0;
        ps = s + 1 + pr;
        a  = (ab >= 0) ? s + ab : (1 << 30);
        rs = restart ? s + 1 + int'($urandom_range(1, 0)) : -1;
        for (int k = 1; k <= (rl ? 100 : 1); k++) begin
            t = s + 1 + k * n + w;
            if (t >= a) break;
            x.is_err = 1'b0; x.at = t + 1; x.q = rl ? p : '0; x.busy = rl;
            sb.push_back(x);
        end
        e = (ab >= 0) ? a + 3 : s + 3 + n + w;
        if (pr > 0 && ps + w + 1 > e) e = ps + w + 1;
        for (int c = s; c <= e; c++) begin
            start       = (c == s) || (c == rs);
            preset      = (c == s) ? p : (4*D)'($urandom);
            auto_reload = (c == s) ? rl : 1'($urandom);
            pause       = (pr > 0) && (c >= ps) && (c < ps + w);
            abort       = (c == a);
            @(posedge clk); #1;
        end
        idle_inputs();
        last_p = p;
        check("missing_done", sb.size(), 0);
        sb.delete();
        check("idle_after", {31'd0, busy}, 32'd0);
        check("q_after", chain_q, 0);
    endtask

    task automatic run_err(input logic [4*D-1:0] p);
        int   s;
        bit   pe_seen;
        exp_t x;
        s = cyc;
        x.is_err = 1'b1; x.at = s + 1; x.q = '0; x.busy = 1'b0;
        sb.push_back(x);
        pe_seen = 1'b0;
        for (int c = s; c <= s + 2; c++) begin
            start = (c == s); preset = p; auto_reload = 1'b1;
            @(posedge clk); #1;
            if (cnt_PE_n !== 1'b1) pe_seen = 1'b1;
        end
        idle_inputs();
        check("err_no_load", {31'd0, pe_seen}, 32'd0);
        check("err_idle", {31'd0, busy}, 32'd0);
        check("err_cnt_P", cnt_P, last_p);
        check("err_missing", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4*D-1:0] p;
        bit             rl;
        int             n, pr, pw, ab;

        idle_inputs();
        MR_n        = 1'b1;
        chain_force = 1'b1;
        #2 MR_n = 1'b0;
        @(posedge clk); #1;
        chain_force = 1'b0;
        check("rst_SR_n", {31'd0, cnt_SR_n}, 32'd0);
        check("rst_PE_n", {31'd0, cnt_PE_n}, 32'd1);
        check("rst_CEP", {31'd0, cnt_CEP}, 32'd0);
        check("rst_CET", {31'd0, cnt_CET}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_done_err", {30'd0, done, err}, 32'd0);
        check("rst_cnt_P", cnt_P, 0);
        MR_n = 1'b1;
        #1;
        check("clear_cycle_SR_n", {31'd0, cnt_SR_n}, 32'd0);
        @(posedge clk); #1;
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_SR_n", {31'd0, cnt_SR_n}, 32'd1);
        check("idle_q", chain_q, 0);
        last_p = '0;

        run_txn(8'h95, 1'b0, 0, 0, -1, 1'b0);           // single interval, done after 15 RUN cycles
        run_txn(8'h95, 1'b1, 0, 0, 1 + 3*15 + 2, 1'b0); // three reloads, then abort
        run_err(8'h9A);
        run_txn(8'h95, 1'b0, 5, 7, -1, 1'b0);           // pause 7 cycles delays done by 7
        run_txn(8'h95, 1'b0, 5, 7, 9, 1'b0);            // abort while paused
        run_txn(8'h95, 1'b0, 0, 0, 16, 1'b0);           // abort on the terminal tick
        run_txn(8'h95, 1'b1, 0, 0, 31, 1'b0);           // abort on the second reload tick
        run_txn(8'h99, 1'b0, 0, 0, -1, 1'b1);           // shortest interval, ignored restart

        // Reset asserted in the middle of RUN.
        start = 1'b1; preset = 8'h50; auto_reload = 1'b0;
        @(posedge clk); #1;
        idle_inputs();
        repeat (20) @(posedge clk);
        #2 MR_n = 1'b0;
        #1;
        check("mid_rst_SR_n", {31'd0, cnt_SR_n}, 32'd0);
        check("mid_rst_PE_n", {31'd0, cnt_PE_n}, 32'd1);
        check("mid_rst_CEP_CET", {30'd0, cnt_CEP, cnt_CET}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd1);
        check("mid_rst_cnt_P", cnt_P, 0);
        @(posedge clk); #1;
        MR_n   = 1'b1;
        last_p = '0;
        @(posedge clk); #1;
        check("mid_rst_idle", {31'd0, busy}, 32'd0);
        check("mid_rst_q", chain_q, 0);

        for (int it = 0; it < 24; it++) begin
            repeat ($urandom_range(2, 0)) begin
                @(posedge clk); #1;
            end
            if ($urandom_range(5, 0) == 0) begin
                p = '0;
                for (int i = 0; i < D; i++) p[4*i +: 4] = 4'($urandom_range(9, 0));
                p[4*$urandom_range(D - 1, 0) +: 4] = 4'($urandom_range(15, 10));
                run_err(p);
            end else begin
                for (int i = 0; i < D; i++) p[4*i +: 4] = 4'($urandom_range(9, 0));
                rl = ($urandom_range(2, 0) == 0);
                n  = interval(p);
                pr = 0; pw = 0;
                if ($urandom_range(1, 0) == 1) begin
                    pr = int'($urandom_range(n - 1, 1));
                    pw = int'($urandom_range(8, 1));
                end
                if (rl)                              ab = int'($urandom_range(3 * n + pw, 1));
                else if ($urandom_range(2, 0) == 0)  ab = int'($urandom_range(n + pw + 1, 1));
                else                                 ab = -1;
                run_txn(p, rl, pr, pw, ab, 1'b1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
